// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy engine: FSM state encoding and word size.
package dma_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_addr_check.sv
// Combinational alignment and range check for one side (source or destination) of a copy.
module dma_addr_check
    import dma_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LEN_W     = 9
) (
    input  logic [31:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             err
);

    // One extra bit so that a region wrapping past 2^32 cannot look in range.
    logic [32:0] end_addr;

    assign end_addr = {1'b0, addr} + (33'(len) * 33'(WORD_BYTES));
    assign err      = (addr[1:0] != 2'b00) || (end_addr > 33'(MEM_BYTES));

endmodule

// File: rtl/dma_copy_engine.sv
// Single-channel word copy engine: alternates one read and one write per word,
// ascending addresses, with an up-front alignment/range check on both regions.
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LEN_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    dma_state_e       state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] remaining;
    logic             src_err;
    logic             dst_err;

    dma_addr_check #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) u_src_check (
        .addr (src_addr),
        .len  (len),
        .err  (src_err)
    );

    dma_addr_check #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) u_dst_check (
        .addr (dst_addr),
        .len  (len),
        .err  (dst_err)
    );

    // All outputs are registered for the state being entered, so the memory
    // strobes line up with the state they belong to; mem_wdata doubles as the
    // data register that holds the word between its read and its write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        if (src_err || dst_err) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err <= 1'b0;
                            if (len == '0) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                mem_rd   <= 1'b1;
                                mem_addr <= src_addr;
                                state    <= READ;
                            end
                        end
                    end
                end

                READ: begin
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b1;
                    mem_addr  <= dst_ptr;
                    mem_wdata <= mem_rdata;
                    state     <= WRITE;
                end

                WRITE: begin
                    mem_wr    <= 1'b0;
                    mem_wdata <= '0;
                    src_ptr   <= src_ptr + 32'(WORD_BYTES);
                    dst_ptr   <= dst_ptr + 32'(WORD_BYTES);
                    remaining <= remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        mem_addr <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= src_ptr + 32'(WORD_BYTES);
                        state    <= READ;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: vector table of copies, a shadow-memory
// write scoreboard, and hand-written reset-abort sequence.
module tb_dma_copy_engine;

    localparam int MEM_BYTES = 1024;
    localparam int LEN_W     = 9;
    localparam int WORDS     = MEM_BYTES / 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic             mem_rd;
    logic             mem_wr;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    logic [31:0] mem    [0:WORDS-1];
    logic [31:0] shadow [0:WORDS-1];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string            name;
        logic [31:0]      src;
        logic [31:0]      dst;
        logic [LEN_W-1:0] len;
        logic             exp_err;
        int               exp_cycle;
        logic             intrude;
    } vec_t;

    wr_t  expq[$];
    vec_t vecs[10];
    int   checks;
    int   errors;
    int   rd_count;
    int   wr_count;

    dma_copy_engine #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus monitor: protocol invariants every cycle, and every write popped against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rd_wr_exclusive", {31'd0, mem_rd && mem_wr}, 32'd0);
            if (!mem_rd && !mem_wr) checkOutput("idle_addr_zero", mem_addr, 32'd0);
            if (!mem_wr) checkOutput("idle_wdata_zero", mem_wdata, 32'd0);
            if (mem_rd) rd_count++;
            if (mem_wr) begin
                wr_count++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write actual=%h required=no_write", mem_addr);
                end else begin
                    wr_t w;
                    w = expq.pop_front();
                    checkOutput("wr_addr", mem_addr, w.addr);
                    checkOutput("wr_data", mem_wdata, w.data);
                end
            end
        end
    end

    task automatic preload();
        for (int i = 0; i < WORDS; i++) begin
            mem[i]    = 32'h1000_0000 + 32'(i);
            shadow[i] = 32'h1000_0000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            mem[i]    = 32'(i + 1);
            shadow[i] = 32'(i + 1);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bit found;
        int c;
        rd_count = 0;
        wr_count = 0;
        if (!v.exp_err) begin
            for (int k = 0; k < int'(v.len); k++) begin
                wr_t w;
                int  s;
                int  d;
                s = int'(v.src[9:2]) + k;
                d = int'(v.dst[9:2]) + k;
                w.addr = v.dst + 32'(4 * k);
                w.data = shadow[s];
                shadow[d] = shadow[s];
                expq.push_back(w);
            end
        end
        @(negedge clk);
        start    = 1'b1;
        src_addr = v.src;
        dst_addr = v.dst;
        len      = v.len;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        c = 0;
        while (!found && c < 600) begin
            @(negedge clk);
            c++;
            if (v.intrude && c == 2) begin
                start    = 1'b1;
                src_addr = 32'h300;
                dst_addr = 32'h340;
                len      = 1;
            end
            if (v.intrude && c == 3) start = 1'b0;
            checkOutput({v.name, "_busy"}, {31'd0, busy}, 32'd1);
            if (done) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=no_done required=done_at_%0d", v.name, v.exp_cycle);
        end else begin
            checkOutput({v.name, "_done_cycle"}, 32'(c), 32'(v.exp_cycle));
            checkOutput({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
            @(negedge clk);
            checkOutput({v.name, "_done_pulse"}, {31'd0, done}, 32'd0);
            checkOutput({v.name, "_busy_after"}, {31'd0, busy}, 32'd0);
            checkOutput({v.name, "_err_sticky"}, {31'd0, err}, {31'd0, v.exp_err});
        end
        checkOutput({v.name, "_pending"}, 32'(expq.size()), 32'd0);
        expq.delete();
        checkOutput({v.name, "_rd_count"}, 32'(rd_count), v.exp_err ? 32'd0 : 32'(v.len));
        checkOutput({v.name, "_wr_count"}, 32'(wr_count), v.exp_err ? 32'd0 : 32'(v.len));
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < WORDS; i++) if (mem[i] !== shadow[i]) bad++;
            checkOutput({v.name, "_mem_image"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rd_count = 0;
        wr_count = 0;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        preload();

        vecs[0] = '{"basic4",     32'h000,      32'h040, 9'd4,   1'b0, 9,   1'b0};
        vecs[1] = '{"len0",       32'h000,      32'h080, 9'd0,   1'b0, 1,   1'b0};
        vecs[2] = '{"src_misal",  32'h002,      32'h040, 9'd1,   1'b1, 1,   1'b0};
        vecs[3] = '{"dst_range",  32'h000,      32'h3FC, 9'd2,   1'b1, 1,   1'b0};
        vecs[4] = '{"overlap",    32'h000,      32'h004, 9'd2,   1'b0, 5,   1'b0};
        vecs[5] = '{"end_fit",    32'h100,      32'h3F8, 9'd2,   1'b0, 5,   1'b0};
        vecs[6] = '{"wrap",       32'hFFFFFFFC, 32'h000, 9'd2,   1'b1, 1,   1'b0};
        vecs[7] = '{"busy_start", 32'h200,      32'h300, 9'd3,   1'b0, 7,   1'b1};
        vecs[8] = '{"dst_misal",  32'h010,      32'h041, 9'd1,   1'b1, 1,   1'b0};
        vecs[9] = '{"long128",    32'h000,      32'h200, 9'd128, 1'b0, 257, 1'b0};

        #1;
        checkOutput("reset_flags", {27'd0, busy, done, err, mem_rd, mem_wr}, 32'd0);
        checkOutput("reset_addr", mem_addr, 32'd0);
        checkOutput("reset_wdata", mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset in cycle 3 of a four-word copy: only the first word may land.
        preload();
        begin
            wr_t w;
            w.addr = 32'h280;
            w.data = 32'h1000_0080;
            expq.push_back(w);
        end
        wr_count = 0;
        @(negedge clk);
        start    = 1'b1;
        src_addr = 32'h200;
        dst_addr = 32'h280;
        len      = 4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_flags", {27'd0, busy, done, err, mem_rd, mem_wr}, 32'd0);
        checkOutput("abort_addr", mem_addr, 32'd0);
        checkOutput("abort_wdata", mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("abort_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_pending", 32'(expq.size()), 32'd0);
        checkOutput("abort_wr_count", 32'(wr_count), 32'd1);
        checkOutput("abort_word0", mem[32'hA0], 32'h1000_0080);
        checkOutput("abort_word1", mem[32'hA1], 32'h1000_00A1);
        expq.delete();

        for (int i = 0; i < 10; i++) begin
            preload();
            applyStimulus(vecs[i]);
            if (i == 0) begin
                for (int k = 0; k < 4; k++) checkOutput("basic4_dst_word", mem[16 + k], 32'(k + 1));
            end
            if (i == 4) begin
                checkOutput("overlap_mem4", mem[1], 32'd1);
                checkOutput("overlap_mem8", mem[2], 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024: byte size of the attached data memory; legal addresses are 0..MEM_BYTES-1.
REQ-002 SHALL have parameter LEN_W, default 9: width of the word-count input.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_addr  input  32  byte address of the first source word.
REQ-007 dst_addr  input  32  byte address of the first destination word.
REQ-008 len  input  LEN_W  number of 32-bit words to copy.
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  sticky error flag; cleared by the next accepted start.
REQ-012 mem_rd  output  1  memory read enable.
REQ-013 mem_wr  output  1  memory write enable; the memory commits on the rising clk edge.
REQ-014 mem_addr  output  32  word-aligned byte address driven to the memory.
REQ-015 mem_wdata  output  32  write data.
REQ-016 mem_rdata  input  32  combinational read data, valid in the same cycle as mem_rd and mem_addr.

Function
REQ-017 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-018 IDLE: mem_rd=mem_wr=0 and busy=0; start=1 latches src_addr, dst_addr and len, and clears err.
- Check at latch: src_addr[1:0]!=0, dst_addr[1:0]!=0, src_addr+4*len>MEM_BYTES or dst_addr+4*len>MEM_BYTES sets err and goes to DONE, with no memory access.
- Otherwise len=0 goes to DONE; any other len goes to READ.
- Address sums SHALL be computed at 33 bits so wrap-around cannot pass the check.
REQ-019 READ: mem_rd=1, mem_addr=current source pointer; mem_rdata is captured into the data register at the clock edge; next state is WRITE.
REQ-020 WRITE: mem_wr=1, mem_addr=current destination pointer, mem_wdata=data register.
- At the edge, both pointers advance by 4 and the remaining count decrements.
- Next state is DONE when the remaining count reaches 0, otherwise READ.
REQ-021 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-022 DONE: done=1 for exactly one cycle, busy=1; next state is IDLE.
REQ-023 A copy of N words SHALL take 2N cycles in READ/WRITE plus 1 cycle in DONE.
- done is high in cycle 2N+1 after the start edge.
REQ-024 Words SHALL be copied in ascending address order.
- Overlapping regions where dst>src propagate the earlier words; this is the defined behaviour.
REQ-025 start while not in IDLE SHALL be ignored.
REQ-026 mem_addr and mem_wdata SHALL be 0 whenever the corresponding enable is low.

Reset
REQ-027 reset=1 SHALL immediately force IDLE and drive busy, done, err, mem_rd, mem_wr, mem_addr and mem_wdata to 0.
REQ-028 Reset mid-copy SHALL abort the copy with no further write.
- Words already written remain in memory.

Structure
REQ-029 State encodings (IDLE=0, READ=1, WRITE=2, DONE=3) and the word-size constant 4 SHALL live in the shared package dma_pkg.
REQ-030 Natural to split out one sub-module, dma_addr_check: combinational alignment and range checker.
- Inputs: addr, len. Output: err.
- Instantiated twice, once for the source and once for the destination.

Verification
REQ-031 Preload mem[0x00..0x0C]=1,2,3,4; start src=0x00, dst=0x40, len=4.
- Required: mem[0x40..0x4C]=1,2,3,4; done in cycle 9; err=0.
REQ-032 start with len=0 -> done in cycle 1; no mem_rd or mem_wr asserted.
REQ-033 src=0x02 -> err=1 and done pulse; no memory access.
- Same result for dst=0x3FC, len=2 with MEM_BYTES=1024.
REQ-034 Overlap case: preload mem[0]=A, mem[4]=B; src=0, dst=4, len=2.
- Required: mem[4]=A, mem[8]=A.
REQ-035 Assert reset in cycle 3 of a len=4 copy.
- Required: only the first destination word is written; all outputs are 0 during reset; IDLE afterwards.
REQ-036 Pulse start again during busy -> ignored; a new start after done is accepted and clears err.
